// File: rtl/apb_seq_pkg.sv
// Shared types for the APB command sequencer: FSM encoding, FIFO entry
// layouts and the helper that builds a response entry.
package apb_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Command entry: {rw, addr, wdata} = 17 bits
    typedef struct packed {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_entry_t;

    // Response entry: {rw, addr, rdata, err, timeout} = 19 bits
    typedef struct packed {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] rdata;
        logic       err;
        logic       timeout;
    } rsp_entry_t;

    // Write completions never carry read data, whatever the slave drives.
    function automatic rsp_entry_t make_rsp(
        input logic       rw,
        input logic [7:0] addr,
        input logic [7:0] rdata,
        input logic       err,
        input logic       timeout
    );
        rsp_entry_t r;
        r.rw      = rw;
        r.addr    = addr;
        r.rdata   = rw ? 8'h00 : rdata;
        r.err     = err;
        r.timeout = timeout;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Push into a full FIFO is only
// accepted together with a pop; pop of an empty FIFO is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage array: data only, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap modulo DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Host-facing command stage for apb_topmodule: buffers commands, issues them
// one at a time, and returns completions through a response FIFO.
module apb_cmd_sequencer
    import apb_seq_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_rw,
    output logic [7:0] rsp_addr,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       rsp_timeout,
    output logic       transfer,
    output logic       read_write,
    output logic [7:0] apb_write_paddr,
    output logic [7:0] apb_read_paddr,
    output logic [7:0] apb_write_data,
    input  logic       pready,
    input  logic       pslaverr,
    input  logic [7:0] prdata,
    output logic       busy
);
    localparam int TW  = $clog2(TIMEOUT);
    localparam int CCW = $clog2(CMD_DEPTH) + 1;
    localparam int RCW = $clog2(RSP_DEPTH) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    seq_state_t     state;
    logic [TW-1:0]  to_cnt;
    cmd_entry_t     cmd_din;
    cmd_entry_t     cmd_head;
    cmd_entry_t     issue;
    rsp_entry_t     rsp_din;
    rsp_entry_t     rsp_head;
    logic           cmd_full;
    logic           cmd_empty;
    logic           rsp_full;
    logic           rsp_empty;
    logic [CCW-1:0] cmd_level;
    logic [RCW-1:0] rsp_level_unused;
    logic           cmd_push;
    logic           cmd_pop;
    logic           rsp_push;
    logic           rsp_pop;
    logic           wait_expired;

    assign cmd_din   = {cmd_rw, cmd_addr, cmd_wdata};
    assign cmd_ready = !cmd_full;
    assign cmd_push  = cmd_valid && !cmd_full;

    // A free response slot is reserved before issuing, so the completion
    // push can never meet a full response FIFO.
    assign cmd_pop = (state == ST_IDLE) && !cmd_empty && !rsp_full;

    assign wait_expired = (to_cnt == TO_LAST);
    assign rsp_push     = (state == ST_WAIT) && (pready || wait_expired);
    assign rsp_din      = make_rsp(issue.rw, issue.addr,
                                   pready ? prdata : 8'h00,
                                   pready ? pslaverr : 1'b1,
                                   !pready);

    assign rsp_valid   = !rsp_empty;
    assign rsp_pop     = rsp_valid && rsp_ready;
    assign rsp_rw      = rsp_head.rw;
    assign rsp_addr    = rsp_head.addr;
    assign rsp_rdata   = rsp_head.rdata;
    assign rsp_err     = rsp_head.err;
    assign rsp_timeout = rsp_head.timeout;

    assign busy = (state != ST_IDLE) || (cmd_level != '0);

    sync_fifo #(
        .WIDTH ($bits(cmd_entry_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (pclk),
        .rst   (preset),
        .push  (cmd_push),
        .din   (cmd_din),
        .pop   (cmd_pop),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_level)
    );

    sync_fifo #(
        .WIDTH ($bits(rsp_entry_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (pclk),
        .rst   (preset),
        .push  (rsp_push),
        .din   (rsp_din),
        .pop   (rsp_pop),
        .dout  (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_level_unused)
    );

    // Issue register: holds the in-flight command for building its response.
    always_ff @(posedge pclk) begin
        if (cmd_pop) begin
            issue <= cmd_head;
        end
    end

    // Transfer FSM with registered APB-side outputs.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state           <= ST_IDLE;
            to_cnt          <= '0;
            transfer        <= 1'b0;
            read_write      <= 1'b0;
            apb_write_paddr <= 8'h00;
            apb_read_paddr  <= 8'h00;
            apb_write_data  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_pop) begin
                        state      <= ST_ISSUE;
                        transfer   <= 1'b1;
                        read_write <= cmd_head.rw;
                        if (cmd_head.rw) begin
                            apb_write_paddr <= cmd_head.addr;
                            apb_write_data  <= cmd_head.wdata;
                            apb_read_paddr  <= 8'h00;
                        end else begin
                            apb_write_paddr <= 8'h00;
                            apb_write_data  <= 8'h00;
                            apb_read_paddr  <= cmd_head.addr;
                        end
                    end
                end
                ST_ISSUE: begin
                    // pready seen here is ignored; only WAIT samples it.
                    state  <= ST_WAIT;
                    to_cnt <= '0;
                end
                ST_WAIT: begin
                    if (pready || wait_expired) begin
                        state           <= ST_DONE;
                        transfer        <= 1'b0;
                        read_write      <= 1'b0;
                        apb_write_paddr <= 8'h00;
                        apb_read_paddr  <= 8'h00;
                        apb_write_data  <= 8'h00;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed bench for apb_cmd_sequencer with a behavioural APB slave stub.
module tb_apb_cmd_sequencer;

    logic       pclk      = 1'b0;
    logic       preset    = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw    = 1'b0;
    logic [7:0] cmd_addr  = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_rw;
    logic [7:0] rsp_addr;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       transfer;
    logic       read_write;
    logic [7:0] apb_write_paddr;
    logic [7:0] apb_read_paddr;
    logic [7:0] apb_write_data;
    logic       pready;
    logic       pslaverr;
    logic [7:0] prdata;
    logic       busy;

    logic       slave_en  = 1'b1;
    logic       slave_err = 1'b0;
    logic [7:0] smem [256];
    int         xfer_cyc  = 0;
    int         rise_cnt  = 0;
    int         hi_cnt    = 0;
    logic       transfer_q = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 pclk = ~pclk;

    apb_cmd_sequencer #(
        .CMD_DEPTH (4),
        .RSP_DEPTH (4),
        .TIMEOUT   (16)
    ) dut (
        .pclk            (pclk),
        .preset          (preset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_rw          (cmd_rw),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rw          (rsp_rw),
        .rsp_addr        (rsp_addr),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .rsp_timeout     (rsp_timeout),
        .transfer        (transfer),
        .read_write      (read_write),
        .apb_write_paddr (apb_write_paddr),
        .apb_read_paddr  (apb_read_paddr),
        .apb_write_data  (apb_write_data),
        .pready          (pready),
        .pslaverr        (pslaverr),
        .prdata          (prdata),
        .busy            (busy)
    );

    // Slave stub: one wait state after the first transfer cycle; writes
    // drive nonzero prdata so forced-zero write rdata is observable.
    assign pready   = slave_en && transfer && (xfer_cyc >= 1);
    assign pslaverr = slave_err;
    assign prdata   = read_write ? 8'hEE : smem[apb_read_paddr];

    // Slave memory plus transfer rise/high-cycle counters.
    always @(posedge pclk) begin
        xfer_cyc <= transfer ? xfer_cyc + 1 : 0;
        if (transfer && pready && read_write) smem[apb_write_paddr] <= apb_write_data;
        if (transfer && !transfer_q) rise_cnt <= rise_cnt + 1;
        if (transfer) hi_cnt <= hi_cnt + 1;
        transfer_q <= transfer;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic rw, input logic [7:0] addr, input logic [7:0] wdata);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        while (!cmd_ready && n < 200) begin
            @(posedge pclk); #1;
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL send_wait: cmd_ready=%b required 1 within 200 cycles (addr %h)", cmd_ready, addr);
        end
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [18:0] r);
        int n;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(posedge pclk); #1;
            n++;
        end
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_wait: rsp_valid=%b required 1 within 200 cycles", rsp_valid);
        end
        r = {rsp_rw, rsp_addr, rsp_rdata, rsp_err, rsp_timeout};
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        checks++;
        if (transfer !== 1'b0) begin errors++; $display("FAIL reset_hold_transfer: got %b want 0", transfer); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_rsp_valid: got %b want 0", rsp_valid); end
        preset = 1'b0;
        @(posedge pclk); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++;
        if ({transfer, read_write} !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %b want 00", {transfer, read_write}); end
        checks++;
        if ({apb_write_paddr, apb_read_paddr, apb_write_data} !== 24'h0) begin
            errors++;
            $display("FAIL reset_apb_bus: got %h want 000000", {apb_write_paddr, apb_read_paddr, apb_write_data});
        end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_write_read();
        logic        prev;
        int          rises;
        int          low_run;
        int          gap;
        logic [24:0] rd_issue;
        logic [18:0] r;
        slave_en  = 1'b1;
        slave_err = 1'b0;
        rd_issue  = '1;
        send(1'b1, 8'h15, 8'hA5);
        // Edge after acceptance is the IDLE decision cycle.
        checks++;
        if (transfer !== 1'b0) begin errors++; $display("FAIL wr_decision_cycle: transfer=%b want 0", transfer); end
        send(1'b0, 8'h15, 8'h00);
        checks++;
        if ({transfer, read_write, apb_write_paddr, apb_read_paddr, apb_write_data} !== {1'b1, 1'b1, 8'h15, 8'h00, 8'hA5}) begin
            errors++;
            $display("FAIL wr_issue_outputs: got %h want %h",
                     {transfer, read_write, apb_write_paddr, apb_read_paddr, apb_write_data},
                     {1'b1, 1'b1, 8'h15, 8'h00, 8'hA5});
        end
        prev    = 1'b1;
        rises   = 1;
        low_run = 0;
        gap     = -1;
        for (int i = 0; i < 16; i++) begin
            @(posedge pclk); #1;
            if (transfer && !prev) begin
                rises++;
                gap      = low_run;
                rd_issue = {read_write, apb_read_paddr, apb_write_paddr, apb_write_data};
            end
            low_run = transfer ? 0 : low_run + 1;
            prev    = transfer;
        end
        checks++;
        if (rises !== 2) begin errors++; $display("FAIL wr_rd_pulses: got %0d want 2", rises); end
        checks++;
        if (gap !== 2) begin errors++; $display("FAIL wr_rd_idle_gap: got %0d want 2", gap); end
        checks++;
        if (rd_issue !== {1'b0, 8'h15, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL rd_issue_outputs: got %h want %h", rd_issue, {1'b0, 8'h15, 8'h00, 8'h00});
        end
        get_rsp(r);
        checks++;
        if (r !== {1'b1, 8'h15, 8'h00, 1'b0, 1'b0}) begin
            errors++; $display("FAIL wr_rsp: got %h want %h", r, {1'b1, 8'h15, 8'h00, 1'b0, 1'b0});
        end
        get_rsp(r);
        checks++;
        if (r !== {1'b0, 8'h15, 8'hA5, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rd_rsp: got %h want %h", r, {1'b0, 8'h15, 8'hA5, 1'b0, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] exp_rsp [5];
        logic [18:0] r;
        exp_rsp[0] = {1'b1, 8'h20, 8'h00, 1'b0, 1'b0};
        exp_rsp[1] = {1'b1, 8'h30, 8'h00, 1'b0, 1'b0};
        exp_rsp[2] = {1'b0, 8'h20, 8'hB5, 1'b0, 1'b0};
        exp_rsp[3] = {1'b0, 8'h30, 8'h65, 1'b0, 1'b0};
        exp_rsp[4] = {1'b1, 8'h40, 8'h00, 1'b0, 1'b0};
        send(1'b1, 8'h20, 8'hB5);
        send(1'b1, 8'h30, 8'h65);
        send(1'b0, 8'h20, 8'h00);
        send(1'b0, 8'h30, 8'h00);
        send(1'b1, 8'h40, 8'h11);
        // One command popped, four queued: FIFO full.
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b want 0", cmd_ready); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
        for (int i = 0; i < 5; i++) begin
            get_rsp(r);
            checks++;
            if (r !== exp_rsp[i]) begin
                errors++; $display("FAIL b2b_rsp%0d: got %h want %h", i, r, exp_rsp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int          r0;
        logic [18:0] r;
        rsp_ready = 1'b0;
        r0 = rise_cnt;
        for (int i = 0; i < 6; i++) begin
            send(1'b1, 8'(8'h50 + i), 8'(8'hC0 + i));
        end
        repeat (40) @(posedge pclk);
        #1;
        checks++;
        if (rise_cnt - r0 !== 4) begin errors++; $display("FAIL bp_issued: got %0d want 4", rise_cnt - r0); end
        checks++;
        if ({transfer, busy, rsp_valid} !== 3'b011) begin
            errors++; $display("FAIL bp_stall_state: transfer,busy,rsp_valid got %b want 011", {transfer, busy, rsp_valid});
        end
        for (int i = 0; i < 6; i++) begin
            get_rsp(r);
            checks++;
            if (r !== {1'b1, 8'(8'h50 + i), 8'h00, 1'b0, 1'b0}) begin
                errors++; $display("FAIL bp_rsp%0d: got %h want %h", i, r, {1'b1, 8'(8'h50 + i), 8'h00, 1'b0, 1'b0});
            end
        end
        repeat (10) @(posedge pclk);
        #1;
        checks++;
        if (rise_cnt - r0 !== 6) begin errors++; $display("FAIL bp_resumed: got %0d want 6", rise_cnt - r0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_drained_busy: got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        int          h0;
        logic [18:0] r;
        slave_en = 1'b0;
        h0 = hi_cnt;
        send(1'b0, 8'h60, 8'h00);
        get_rsp(r);
        checks++;
        if (r !== {1'b0, 8'h60, 8'h00, 1'b1, 1'b1}) begin
            errors++; $display("FAIL to_rsp: got %h want %h", r, {1'b0, 8'h60, 8'h00, 1'b1, 1'b1});
        end
        repeat (2) @(posedge pclk);
        #1;
        // One ISSUE cycle plus 16 WAIT cycles.
        checks++;
        if (hi_cnt - h0 !== 17) begin errors++; $display("FAIL to_high_cycles: got %0d want 17", hi_cnt - h0); end
        slave_en = 1'b1;
        send(1'b1, 8'h61, 8'h3C);
        get_rsp(r);
        checks++;
        if (r !== {1'b1, 8'h61, 8'h00, 1'b0, 1'b0}) begin
            errors++; $display("FAIL to_next_rsp: got %h want %h", r, {1'b1, 8'h61, 8'h00, 1'b0, 1'b0});
        end
    endtask

    task automatic test_slverr();
        logic [18:0] r;
        slave_err = 1'b1;
        send(1'b0, 8'hFF, 8'h00);
        get_rsp(r);
        slave_err = 1'b0;
        checks++;
        if ({r[18], r[17:10], r[1], r[0]} !== {1'b0, 8'hFF, 1'b1, 1'b0}) begin
            errors++; $display("FAIL slverr_rsp: rw,addr,err,timeout got %h want %h", {r[18], r[17:10], r[1], r[0]}, {1'b0, 8'hFF, 1'b1, 1'b0});
        end
    endtask

    task automatic test_reset_mid();
        slave_en = 1'b0;
        send(1'b0, 8'h70, 8'h00);
        send(1'b1, 8'h71, 8'h01);
        send(1'b1, 8'h72, 8'h02);
        repeat (3) @(posedge pclk);
        #1;
        checks++;
        if ({transfer, busy} !== 2'b11) begin errors++; $display("FAIL mid_pre_state: transfer,busy got %b want 11", {transfer, busy}); end
        #3;
        preset = 1'b1;
        #1;
        checks++;
        if (transfer !== 1'b0) begin errors++; $display("FAIL mid_async_transfer: got %b want 0", transfer); end
        @(posedge pclk); #1;
        preset = 1'b0;
        @(posedge pclk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_cmd_ready: got %b want 1", cmd_ready); end
        checks++;
        if (transfer !== 1'b0) begin errors++; $display("FAIL mid_transfer_after: got %b want 0", transfer); end
        slave_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_slverr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
